// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_IA = 2'b00,
        MODE_IB = 2'b01,
        MODE_DA = 2'b10,
        MODE_DB = 2'b11
    } mode_t;

    localparam logic [3:0] REG_PC = 4'd15;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// 16-bit find-first-set: index of the lowest set bit plus a non-empty flag.
module lowest_set_bit (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int unsigned i = 16; i > 0; i--) begin
            if (vec[i-1]) begin
                idx = 4'(i - 1);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer with optional base writeback.
// Define LDM_PC_LOAD_EN to allow R15 in the list and expose the pc_* ports.
module ldm_stm_seq
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [1:0]        mode,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    output logic [3:0]        str_addr,
    input  logic [31:0]       str_data,
`ifdef LDM_PC_LOAD_EN
    output logic              pc_wr_en,
    output logic [ADDR_W-1:0] pc_wr_data,
    input  logic [ADDR_W-1:0] pc_value,
`endif
    output logic [3:0]        w_addr_ldr,
    output logic [31:0]       w_data_ldr,
    output logic              w_en_ldr
);

    state_t            state;
    logic              ld_q;
    logic              wb_q;
    mode_t             mode_q;
    logic [3:0]        base_reg_q;
    logic [15:0]       list_q;
    logic [15:0]       rem;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        count_q;
    logic              wb_sel;

    logic [15:0]       masked;
    logic [4:0]        count_in;
    logic [ADDR_W-1:0] first_addr;
    logic [15:0]       lsb_in;
    logic [15:0]       rem_next;
    logic [3:0]        lsb_idx;
    logic              lsb_valid;
    logic [ADDR_W-1:0] wb_value;
    logic              go_wb;
    logic              wb_en_nxt;
    logic [3:0]        wb_reg_nxt;

    lowest_set_bit u_lsb (
        .vec   (lsb_in),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    always_comb begin
`ifdef LDM_PC_LOAD_EN
        masked = reg_list;
`else
        masked = reg_list & ~(16'd1 << REG_PC);
`endif
        count_in = popcount16(masked);
        case (mode_t'(mode))
            MODE_IA: first_addr = base_addr;
            MODE_IB: first_addr = base_addr + ADDR_W'(1);
            MODE_DA: first_addr = base_addr - ADDR_W'(count_in) + ADDR_W'(1);
            default: first_addr = base_addr - ADDR_W'(count_in);
        endcase

        // One priority encoder serves both the start cycle and XFER.
        lsb_in   = (state == IDLE) ? masked : rem;
        rem_next = lsb_in & ~(16'd1 << lsb_idx);

        if (mode_q inside {MODE_IA, MODE_IB}) begin
            wb_value = base_q + ADDR_W'(count_q);
        end else begin
            wb_value = base_q - ADDR_W'(count_q);
        end

        // Entering WB straight from IDLE means the list is empty, so the
        // raw inputs decide the writeback and no suppression can apply.
        go_wb = (state == IDLE && start && !lsb_valid) ||
                (state == XFER && !lsb_valid && !ld_q) ||
                (state == TAIL);
        if (state == IDLE) begin
            wb_en_nxt  = writeback;
            wb_reg_nxt = base_reg;
        end else begin
            wb_en_nxt  = wb_q && !(ld_q && list_q[base_reg_q]);
            wb_reg_nxt = base_reg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            w_en_ldr   <= 1'b0;
            wb_sel     <= 1'b0;
            mem_addr   <= '0;
            str_addr   <= '0;
            w_addr_ldr <= '0;
            rem        <= '0;
            ld_q       <= 1'b0;
            wb_q       <= 1'b0;
            mode_q     <= MODE_IA;
            base_reg_q <= '0;
            list_q     <= '0;
            base_q     <= '0;
            count_q    <= '0;
`ifdef LDM_PC_LOAD_EN
            pc_wr_en   <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            w_en_ldr  <= 1'b0;
            wb_sel    <= 1'b0;
`ifdef LDM_PC_LOAD_EN
            pc_wr_en  <= 1'b0;
`endif

            // Load data arrives the cycle after each XFER read.
            if (state == XFER && ld_q) begin
`ifdef LDM_PC_LOAD_EN
                if (str_addr == REG_PC) begin
                    pc_wr_en <= 1'b1;
                end else begin
                    w_en_ldr   <= 1'b1;
                    w_addr_ldr <= str_addr;
                end
`else
                w_en_ldr   <= 1'b1;
                w_addr_ldr <= str_addr;
`endif
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ld_q       <= is_load;
                        wb_q       <= writeback;
                        mode_q     <= mode_t'(mode);
                        base_reg_q <= base_reg;
                        list_q     <= masked;
                        base_q     <= base_addr;
                        count_q    <= count_in;
                        busy       <= 1'b1;
                        if (lsb_valid) begin
                            state     <= XFER;
                            mem_addr  <= first_addr;
                            str_addr  <= lsb_idx;
                            rem       <= rem_next;
                            mem_rd_en <= is_load;
                            mem_wr_en <= !is_load;
                        end else begin
                            state <= WB;
                        end
                    end
                end
                XFER: begin
                    if (lsb_valid) begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        str_addr  <= lsb_idx;
                        rem       <= rem_next;
                        mem_rd_en <= ld_q;
                        mem_wr_en <= !ld_q;
                    end else begin
                        state <= ld_q ? TAIL : WB;
                    end
                end
                TAIL: state <= WB;
                WB: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (go_wb) begin
                done   <= 1'b1;
                wb_sel <= 1'b1;
                if (wb_en_nxt) begin
                    w_en_ldr   <= 1'b1;
                    w_addr_ldr <= wb_reg_nxt;
                end
            end
        end
    end

    assign w_data_ldr = wb_sel ? 32'(wb_value) : mem_rd_data;

`ifdef LDM_PC_LOAD_EN
    assign mem_wr_data = (str_addr == REG_PC) ? 32'(pc_value) : str_data;
    assign pc_wr_data  = mem_rd_data[ADDR_W-1:0];
`else
    assign mem_wr_data = str_data;
`endif

endmodule
